// File: rtl/approx_ks_adder_pipe_if.sv
// Handshake/data bundle for approx_ks_adder_pipe.
//   master : operand producer and result consumer (drives in_*, out_ready)
//   slave  : the adder pipeline (drives in_ready, out_*, err_*)
// Signals: in_valid/in_ready/in_a/in_b/in_cin/in_approx (operand beat),
//          out_valid/out_ready/out_sum/out_cout (result beat),
//          err_flag/err_count (error monitor, zero unless ERR_MON_EN).
interface approx_ks_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             err_flag;
  logic [15:0]      err_count;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_approx, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, err_flag, err_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_approx, out_ready,
    output in_ready, out_valid, out_sum, out_cout, err_flag, err_count
  );
endinterface

// File: rtl/approx_ks_adder_pipe.sv
// Two-stage pipelined Kogge-Stone adder with a per-beat approximate low segment.
// Approximate mode: the low APPROX_K bits use c_i = g_{i-1} (no propagation),
// the upper bits are an exact prefix with carry-in g_{APPROX_K-1}; cin ignored.
// Parameters: WIDTH (>=4) operand width, APPROX_K (0..WIDTH-1, 0 = always exact).
// Ports: clk, rst_n (async active-low), bus (approx_ks_adder_pipe_if.slave).
// Optional macro ERR_MON_EN: builds an exact reference adder, err_flag and a
// saturating err_count; otherwise err_flag/err_count are tied to zero.
module approx_ks_adder_pipe #(
  parameter int WIDTH    = 16,
  parameter int APPROX_K = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  approx_ks_adder_pipe_if.slave bus
);
  localparam int unsigned W      = WIDTH;
  localparam int unsigned KU     = APPROX_K;
  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic             s1_v, s1_cin, s1_approx;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s2_v, s2_cout;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_load, s2_leave;
  logic [WIDTH-1:0] sum_n;
  logic             cout_n;

  // Kogge-Stone prefix: returns group generate G[i:0] for every bit i.
  function automatic logic [WIDTH-1:0] ks_prefix(input logic [WIDTH-1:0] g_in,
                                                 input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g_c, p_c, g_n, p_n;
    int unsigned step;
    g_c = g_in;
    p_c = p_in;
    for (int unsigned lv = 0; lv < LEVELS; lv++) begin
      step = 1 << lv;
      g_n  = g_c;
      p_n  = p_c;
      for (int unsigned i = step; i < W; i++) begin
        g_n[i] = g_c[i] | (p_c[i] & g_c[i-step]);
        p_n[i] = p_c[i] & p_c[i-step];
      end
      g_c = g_n;
      p_c = p_n;
    end
    return g_c;
  endfunction

  assign s2_leave     = s2_v & bus.out_ready;
  assign s2_load      = s1_v & (~s2_v | bus.out_ready);
  assign bus.in_ready = ~s1_v | ~s2_v | bus.out_ready;
  assign bus.out_valid = s2_v;
  assign bus.out_sum   = s2_sum;
  assign bus.out_cout  = s2_cout;

  // One shared prefix tree serves both modes: in approximate mode the low
  // segment is masked off the tree except g_{K-1}, which becomes the upper
  // segment's carry-in; the low sum bits are then overridden directly.
  always_comb begin
    logic [WIDTH-1:0] p, g, tg, tp, gpre, carry;
    logic apx;
    apx  = s1_approx && (KU != 0);
    p    = s1_a ^ s1_b;
    g    = s1_a & s1_b;
    tg   = g;
    tp   = p;
    if (apx) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (i < KU) begin
          tp[i] = 1'b0;
          tg[i] = (i + 1 == KU) ? g[i] : 1'b0;
        end
      end
    end else begin
      tg[0] = g[0] | (p[0] & s1_cin);
    end
    gpre   = ks_prefix(tg, tp);
    carry  = {gpre[WIDTH-2:0], (apx ? 1'b0 : s1_cin)};
    sum_n  = p ^ carry;
    cout_n = gpre[WIDTH-1];
    if (apx) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (i < KU) begin
          if (i == 0) sum_n[i] = p[i];
          else        sum_n[i] = p[i] ^ g[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_cin    <= 1'b0;
      s1_approx <= 1'b0;
    end else if (bus.in_ready) begin
      // in_ready means S1 is empty or draining, so its valid follows in_valid
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a      <= bus.in_a;
        s1_b      <= bus.in_b;
        s1_cin    <= bus.in_cin;
        s1_approx <= bus.in_approx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_sum  <= '0;
      s2_cout <= 1'b0;
    end else if (s2_load) begin
      s2_v    <= 1'b1;
      s2_sum  <= sum_n;
      s2_cout <= cout_n;
    end else if (s2_leave) begin
      s2_v <= 1'b0;
    end
  end

`ifdef ERR_MON_EN
  logic         err_n, s2_err;
  logic [15:0]  err_cnt;
  logic [WIDTH:0] exact_n;

  always_comb begin
    exact_n = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
    err_n   = ({cout_n, sum_n} != exact_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_err  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (s2_load) s2_err <= err_n;
      if (s2_leave && s2_err && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.err_flag  = s2_err;
  assign bus.err_count = err_cnt;
`else
  assign bus.err_flag  = 1'b0;
  assign bus.err_count = '0;
`endif
endmodule
